if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
Instruction-fetch stage. It owns the program counter and feeds the current PC and PC+4 to the PC-select mux. It loads the mux's next-PC output, issues single-outstanding requests to instruction memory, and drives the IF/ID pipeline register toward decode. It also handles decode stalls with a one-entry hold buffer and discards wrong-path fetches on redirect.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INST, 32'h0000_0013, instruction presented on io_id_inst when invalid/reset (addi x0,x0,0)

Ports:
clock  input  1  single clock, all state on rising edge
reset  input  1  asynchronous, active-high
io_next_pc  input  32  next PC from PC-select mux output
io_pc  output  32  current PC register
io_pc_4  output  32  io_pc + 4, wraps mod 2^32
io_redirect  input  1  jump/branch taken this cycle; flush and reload PC
io_stall  input  1  decode cannot accept IF/ID contents this cycle
io_imem_req_valid  output  1  fetch request valid
io_imem_req_ready  input  1  memory accepts request this cycle
io_imem_req_addr  output  32  fetch address (= io_pc)
io_imem_resp_valid  input  1  response data valid (exactly one per accepted request)
io_imem_resp_data  input  32  fetched instruction
io_id_valid  output  1  IF/ID holds a valid instruction
io_id_pc  output  32  PC of IF/ID instruction
io_id_inst  output  32  IF/ID instruction

Behaviour:
- Reset values (async assert):
  - pc = RESET_PC; state = REQ; io_id_valid = 0; io_id_pc = 0; io_id_inst = NOP_INST; hold buffer empty.
  - io_imem_req_valid = 0 while reset is asserted; it is 1 from the first cycle after release.
- io_pc_4 is combinational pc + 4 with no carry-out: 32'hFFFF_FFFC -> 32'h0000_0000.
- PC loads are always io_next_pc with bits [1:0] forced to 0.
- State REQ:
  - req_valid = 1, req_addr = pc.
  - On ready -> WAIT.
  - Address may change before acceptance only through a redirect; imem tolerates this.
- State WAIT: on resp_valid, the instruction is deliverable.
  - If IF/ID empty, or IF/ID valid and !io_stall: load IF/ID (valid = 1, pc, data) at that edge; pc <= io_next_pc; -> REQ.
  - Else, IF/ID full and stalled: capture into hold buffer (pc, data); -> HOLD.
- State HOLD:
  - req_valid = 0.
  - When !io_stall: hold buffer -> IF/ID; pc <= io_next_pc; -> REQ.
- State KILL:
  - req_valid = 0.
  - Wait for resp_valid; discard the data; -> REQ.
- IF/ID drain: when !io_stall and no new load this edge, io_id_valid <= 0. IF/ID contents are frozen while io_stall && io_id_valid.
- Latency: request accepted at cycle N, response at N+k (k >= 1). IF/ID is visible at N+k+1 and the next request is issued at N+k+1. Peak throughput is 1 instruction per 2 cycles with k = 1.
- Redirect: highest priority; overrides stall and any same-cycle delivery.
  - Effects: pc <= io_next_pc; io_id_valid <= 0; hold buffer cleared.
  - Next state: from REQ without acceptance -> REQ; from HOLD -> REQ.
  - From WAIT without resp_valid this cycle -> KILL. From WAIT with resp_valid this cycle -> response discarded, -> REQ.
  - From REQ with ready this cycle (the accepted request is wrong-path) -> KILL.
- Redirect during KILL: pc reloaded; remain in KILL.
- Reset mid-operation: immediate return to reset values. Any in-flight imem response arriving after reset release is not expected (imem is reset together with this block).

Decomposition:
- Shared package holds:
  - state encoding REQ=2'd0, WAIT=2'd1, HOLD=2'd2, KILL=2'd3;
  - NOP_INST and RESET_PC defaults;
  - IF/ID bundle fields (valid, pc, inst), reused by the decode stage.
- One natural sub-module: if_id_reg, the IF/ID register plus hold buffer with load/flush/stall controls. The FSM and PC register stay in if_stage.

Test Plan:
- Reset release, imem ready = 1, 1-cycle response, io_next_pc = io_pc_4, no stall -> requests to 0x0, 0x4, 0x8 on alternating cycles; io_id_pc sequence 0x0, 0x4, 0x8 with io_id_valid pulsing.
- io_stall held 4 cycles while IF/ID valid (pc 0x4) and response for 0x8 arrives -> IF/ID frozen at 0x4; 0x8 held in buffer; no new request. On stall drop -> IF/ID = 0x8, next request 0xC.
- Redirect with io_next_pc = 0x100 while in WAIT, response arrives 2 cycles later with 0xDEADBEEF -> data discarded; io_id_valid = 0; next request addr 0x100.
- Redirect in the same cycle as resp_valid and io_stall = 1 -> response dropped; IF/ID invalidated; pc = redirect target; state REQ next cycle.
- Force pc to 0xFFFF_FFFC (via redirect), io_next_pc = io_pc_4 -> io_pc_4 = 0x0; next fetch address 0x0. io_next_pc = 0x103 -> pc loads 0x100.
- Assert reset during HOLD -> next cycle io_id_valid = 0, io_id_inst = 0x0000_0013, pc = RESET_PC, req_valid = 0 until release.

Source files
------------

// File: rtl/if_stage_pkg.sv
// rtl/if_stage_pkg.sv - shared fetch-stage types, defaults and helpers
package if_stage_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0013;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2,
        KILL = 2'd3
    } state_t;

    // IF/ID bundle, also consumed by the decode stage
    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] inst;
    } if_id_t;

    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return addr & ~32'h3;
    endfunction

endpackage

// File: rtl/if_stage_id_reg.sv
// rtl/if_stage_id_reg.sv - IF/ID pipeline register with one-entry hold buffer
module if_id_reg
    import if_stage_pkg::*;
#(
    parameter logic [31:0] NOP_INST = NOP_INST_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        flush,
    input  logic        stall,
    input  logic        load,
    input  logic        capture,
    input  logic        release_hold,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_inst,
    output if_id_t      id
);

    if_id_t      id_q;
    logic        hold_valid;
    logic [31:0] hold_pc;
    logic [31:0] hold_inst;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            id_q       <= '{valid: 1'b0, pc: 32'h0, inst: NOP_INST};
            hold_valid <= 1'b0;
            hold_pc    <= 32'h0;
            hold_inst  <= NOP_INST;
        end else if (flush) begin
            id_q.valid <= 1'b0;
            hold_valid <= 1'b0;
        end else if (load) begin
            id_q <= '{valid: 1'b1, pc: in_pc, inst: in_inst};
        end else if (capture) begin
            hold_valid <= 1'b1;
            hold_pc    <= in_pc;
            hold_inst  <= in_inst;
        end else if (release_hold && hold_valid) begin
            id_q       <= '{valid: 1'b1, pc: hold_pc, inst: hold_inst};
            hold_valid <= 1'b0;
        end else if (!stall) begin
            id_q.valid <= 1'b0;
        end
    end

    // Decode always sees a harmless NOP when the slot is empty
    assign id = '{valid: id_q.valid, pc: id_q.pc,
                  inst: id_q.valid ? id_q.inst : NOP_INST};

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage: PC register, imem request FSM, IF/ID
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INST = NOP_INST_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] io_next_pc,
    output logic [31:0] io_pc,
    output logic [31:0] io_pc_4,
    input  logic        io_redirect,
    input  logic        io_stall,
    output logic        io_imem_req_valid,
    input  logic        io_imem_req_ready,
    output logic [31:0] io_imem_req_addr,
    input  logic        io_imem_resp_valid,
    input  logic [31:0] io_imem_resp_data,
    output logic        io_id_valid,
    output logic [31:0] io_id_pc,
    output logic [31:0] io_id_inst
);

    state_t      state, state_nxt;
    logic [31:0] pc;
    logic        pc_load;
    logic        id_load, id_capture, id_release;
    if_id_t      id;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= REQ;
            pc    <= RESET_PC;
        end else begin
            state <= state_nxt;
            if (pc_load) pc <= align_pc(io_next_pc);
        end
    end

    always_comb begin
        state_nxt         = state;
        pc_load           = io_redirect;
        id_load           = 1'b0;
        id_capture        = 1'b0;
        id_release        = 1'b0;
        io_imem_req_valid = 1'b0;
        case (state)
            REQ: begin
                io_imem_req_valid = !reset;
                // An accepted request under redirect is wrong-path and must be drained
                if (io_imem_req_ready) state_nxt = io_redirect ? KILL : WAIT;
            end
            WAIT: begin
                if (io_redirect) begin
                    state_nxt = io_imem_resp_valid ? REQ : KILL;
                end else if (io_imem_resp_valid) begin
                    if (!id.valid || !io_stall) begin
                        id_load   = 1'b1;
                        pc_load   = 1'b1;
                        state_nxt = REQ;
                    end else begin
                        id_capture = 1'b1;
                        state_nxt  = HOLD;
                    end
                end
            end
            HOLD: begin
                if (io_redirect) begin
                    state_nxt = REQ;
                end else if (!io_stall) begin
                    id_release = 1'b1;
                    pc_load    = 1'b1;
                    state_nxt  = REQ;
                end
            end
            KILL: begin
                if (io_imem_resp_valid) state_nxt = REQ;
            end
        endcase
    end

    if_id_reg #(.NOP_INST(NOP_INST)) u_if_id_reg (
        .clock        (clock),
        .reset        (reset),
        .flush        (io_redirect),
        .stall        (io_stall),
        .load         (id_load),
        .capture      (id_capture),
        .release_hold (id_release),
        .in_pc        (pc),
        .in_inst      (io_imem_resp_data),
        .id           (id)
    );

    assign io_pc            = pc;
    assign io_pc_4          = pc + 32'd4;
    assign io_imem_req_addr = pc;
    assign io_id_valid      = id.valid;
    assign io_id_pc         = id.pc;
    assign io_id_inst       = id.inst;

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - randomized and directed check of if_stage against a transaction model
module tb_if_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] io_next_pc = '0;
    logic [31:0] io_pc, io_pc_4;
    logic        io_redirect = 1'b0;
    logic        io_stall = 1'b0;
    logic        io_imem_req_valid;
    logic        io_imem_req_ready = 1'b0;
    logic [31:0] io_imem_req_addr;
    logic        io_imem_resp_valid = 1'b0;
    logic [31:0] io_imem_resp_data = '0;
    logic        io_id_valid;
    logic [31:0] io_id_pc, io_id_inst;

    int total = 0;
    int bad   = 0;

    if_stage dut (
        .clock              (clock),
        .reset              (reset),
        .io_next_pc         (io_next_pc),
        .io_pc              (io_pc),
        .io_pc_4            (io_pc_4),
        .io_redirect        (io_redirect),
        .io_stall           (io_stall),
        .io_imem_req_valid  (io_imem_req_valid),
        .io_imem_req_ready  (io_imem_req_ready),
        .io_imem_req_addr   (io_imem_req_addr),
        .io_imem_resp_valid (io_imem_resp_valid),
        .io_imem_resp_data  (io_imem_resp_data),
        .io_id_valid        (io_id_valid),
        .io_id_pc           (io_id_pc),
        .io_id_inst         (io_id_inst)
    );

    always #5 clock = ~clock;

    // Transaction-level model: one fetch in flight, one parked instruction, one IF/ID slot
    logic [31:0] m_pc, m_req_pc, m_hold_pc, m_hold_inst, m_id_pc, m_id_inst;
    logic        m_out, m_wrong, m_hold_v, m_id_v;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_out = 0; m_wrong = 0; m_req_pc = 0;
        m_hold_v = 0; m_hold_pc = 0; m_hold_inst = 0;
        m_id_v = 0; m_id_pc = 0; m_id_inst = NOP;
    endtask

    function automatic logic exp_req();
        return !reset && !m_out && !m_hold_v;
    endfunction

    task automatic model_update();
        logic accepted, got, old_hold;
        logic [31:0] tgt;
        if (reset) begin
            model_reset();
            return;
        end
        accepted = exp_req() && io_imem_req_ready;
        got      = m_out && io_imem_resp_valid && !m_wrong;
        old_hold = m_hold_v;
        tgt      = io_next_pc & ~32'h3;
        if (io_redirect) begin
            m_pc = tgt; m_id_v = 0; m_hold_v = 0;
            if (accepted) begin m_out = 1; m_wrong = 1; end
            else if (m_out && io_imem_resp_valid) m_out = 0;
            else if (m_out) m_wrong = 1;
        end else begin
            if (accepted) begin m_out = 1; m_wrong = 0; m_req_pc = m_pc; end
            else if (m_out && io_imem_resp_valid) m_out = 0;
            if (got && (!m_id_v || !io_stall)) begin
                m_id_v = 1; m_id_pc = m_req_pc; m_id_inst = io_imem_resp_data; m_pc = tgt;
            end else if (got) begin
                m_hold_v = 1; m_hold_pc = m_req_pc; m_hold_inst = io_imem_resp_data;
            end else if (old_hold && !io_stall) begin
                m_id_v = 1; m_id_pc = m_hold_pc; m_id_inst = m_hold_inst;
                m_hold_v = 0; m_pc = tgt;
            end else if (!io_stall) begin
                m_id_v = 0;
            end
        end
    endtask

    always @(negedge clock) begin
        chk("pc", io_pc, m_pc);
        chk("pc_4", io_pc_4, m_pc + 32'd4);
        chk("req_valid", {31'b0, io_imem_req_valid}, {31'b0, exp_req()});
        if (exp_req()) chk("req_addr", io_imem_req_addr, m_pc);
        chk("id_valid", {31'b0, io_id_valid}, {31'b0, m_id_v});
        if (m_id_v) chk("id_pc", io_id_pc, m_id_pc);
        chk("id_inst", io_id_inst, m_id_v ? m_id_inst : NOP);
    end

    task automatic step(input logic rd, input logic st, input logic rdy, input logic rv,
                        input logic [31:0] data, input logic [31:0] npc);
        io_redirect = rd; io_stall = st; io_imem_req_ready = rdy;
        io_imem_resp_valid = rv; io_imem_resp_data = data; io_next_pc = npc;
        @(posedge clock);
        model_update();
        #1;
    endtask

    initial begin
        logic rd, st, rdy, rv;
        logic [31:0] npc;
        model_reset();
        step(0, 0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        chk("rst_req_valid", {31'b0, io_imem_req_valid}, 32'd0);
        chk("rst_id_valid", {31'b0, io_id_valid}, 32'd0);
        chk("rst_id_pc", io_id_pc, 32'h0);
        chk("rst_id_inst", io_id_inst, NOP);
        chk("rst_pc", io_pc, 32'h0);
        reset = 0;
        #1;
        chk("first_req", {31'b0, io_imem_req_valid}, 32'd1);
        chk("first_addr", io_imem_req_addr, 32'h0);
        // Streaming fetch, 1-cycle memory
        step(0, 0, 1, 0, 0, m_pc + 4);
        chk("wait_no_req", {31'b0, io_imem_req_valid}, 32'd0);
        step(0, 0, 0, 1, 32'h0010_0093, m_pc + 4);
        chk("id0_pc", io_id_pc, 32'h0);
        chk("id0_inst", io_id_inst, 32'h0010_0093);
        chk("req1_addr", io_imem_req_addr, 32'h4);
        step(0, 0, 1, 0, 0, m_pc + 4);
        chk("id_drain", {31'b0, io_id_valid}, 32'd0);
        step(0, 0, 0, 1, 32'h0020_0113, m_pc + 4);
        chk("id1_pc", io_id_pc, 32'h4);
        // Stall with a response landing in the hold buffer
        step(0, 1, 1, 0, 0, m_pc + 4);
        step(0, 1, 0, 1, 32'h0030_0193, m_pc + 4);
        step(0, 1, 0, 0, 0, m_pc + 4);
        step(0, 1, 0, 0, 0, m_pc + 4);
        chk("stall_frozen", io_id_pc, 32'h4);
        chk("hold_no_req", {31'b0, io_imem_req_valid}, 32'd0);
        step(0, 0, 0, 0, 0, m_pc + 4);
        chk("release_pc", io_id_pc, 32'h8);
        chk("release_inst", io_id_inst, 32'h0030_0193);
        chk("after_hold_addr", io_imem_req_addr, 32'hC);
        // Redirect while waiting; late wrong-path response discarded
        step(0, 0, 1, 0, 0, m_pc + 4);
        step(1, 0, 0, 0, 0, 32'h100);
        step(0, 0, 0, 0, 0, m_pc + 4);
        step(0, 0, 0, 1, 32'hDEAD_BEEF, m_pc + 4);
        chk("kill_id_valid", {31'b0, io_id_valid}, 32'd0);
        chk("kill_next_addr", io_imem_req_addr, 32'h100);
        // Redirect together with a response under stall
        step(0, 0, 1, 0, 0, m_pc + 4);
        step(0, 0, 0, 1, 32'h1234_5678, m_pc + 4);
        step(0, 1, 1, 0, 0, m_pc + 4);
        step(1, 1, 0, 1, 32'h0000_0BAD, 32'h200);
        chk("redir_resp_valid", {31'b0, io_id_valid}, 32'd0);
        chk("redir_resp_pc", io_pc, 32'h200);
        chk("redir_resp_req", {31'b0, io_imem_req_valid}, 32'd1);
        // PC wrap and alignment
        step(1, 0, 0, 0, 0, 32'hFFFF_FFFC);
        chk("wrap_pc_4", io_pc_4, 32'h0);
        step(0, 0, 1, 0, 0, m_pc + 4);
        step(0, 0, 0, 1, 32'h0040_0213, m_pc + 4);
        chk("wrap_addr", io_imem_req_addr, 32'h0);
        step(0, 0, 1, 0, 0, m_pc + 4);
        step(0, 0, 0, 1, 32'h0050_0293, 32'h103);
        chk("align_pc", io_pc, 32'h100);
        // Reset while holding
        step(0, 1, 1, 0, 0, m_pc + 4);
        step(0, 1, 0, 1, 32'h0060_0313, m_pc + 4);
        reset = 1;
        model_reset();
        #1;
        chk("hold_rst_valid", {31'b0, io_id_valid}, 32'd0);
        chk("hold_rst_inst", io_id_inst, NOP);
        chk("hold_rst_pc", io_pc, 32'h0);
        step(0, 0, 1, 0, 0, 0);
        chk("hold_rst_req", {31'b0, io_imem_req_valid}, 32'd0);
        reset = 0;
        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 399) == 0) begin
                reset = 1;
                model_reset();
                step(0, 0, 0, 0, 0, 0);
                reset = 0;
            end
            st  = ($urandom_range(0, 2) == 0);
            rdy = $urandom_range(0, 1);
            rv  = m_out && ($urandom_range(0, 1) == 1);
            rd  = ($urandom_range(0, 9) == 0) && !(m_out && m_wrong && rv);
            npc = ($urandom_range(0, 3) == 0) ? $urandom : m_pc + 32'd4;
            step(rd, st, rdy, rv, $urandom, npc);
        end
        @(negedge clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
